// File: rtl/arm_exec_stage.sv
// arm_exec_stage
//   Execute stage between ID/EX and the memory stage. It runs single-cycle
//   ALU and address operations, and MUL/MLA on an iterative multiplier that
//   stalls the upstream pipeline while it works. Store data, byte enables and
//   writeback controls pass through into the EX/MEM register set.
//
// Parameters
//   MUL_BITS_PER_CYCLE   multiplier bits retired per BUSY cycle (1,2,4,8).
//                        K = 32/MUL_BITS_PER_CYCLE BUSY cycles per multiply.
//
// Configuration macro
//   ARM_EX_MUL_EARLY_TERM_EN  when defined, a BUSY cycle whose remaining
//                             (post-shift) multiplier is zero finishes the
//                             multiply early.
//
// Ports
//   clk, rst_b            clock (rising edge), synchronous active-low reset
//   flush                 kill the instruction in EX and any multiply
//   IDEX_*                decoded instruction, operands and controls
//   ex_stall              hold PC, IF/ID and ID/EX this cycle
//   EXMEM_*               registered result and pass-through controls
module arm_exec_stage #(
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        flush,
  input  logic        IDEX_valid,
  input  logic [3:0]  IDEX_alu_op,
  input  logic [31:0] IDEX_op_a,
  input  logic [31:0] IDEX_op_b,
  input  logic        IDEX_is_mul,
  input  logic        IDEX_mul_acc,
  input  logic [31:0] IDEX_acc,
  input  logic [31:0] IDEX_rd_data,
  input  logic        IDEX_rd_we,
  input  logic        IDEX_rd_data_sel,
  input  logic [3:0]  IDEX_des_reg_num,
  input  logic [3:0]  IDEX_mem_write_en,
  input  logic        IDEX_ld_byte_or_word,
  output logic        ex_stall,
  output logic        EXMEM_valid,
  output logic [31:0] EXMEM_data_result,
  output logic [31:0] EXMEM_rd_data,
  output logic        EXMEM_rd_we,
  output logic        EXMEM_rd_data_sel,
  output logic [3:0]  EXMEM_des_reg_num,
  output logic [3:0]  EXMEM_mem_write_en,
  output logic        EXMEM_ld_byte_or_word
);

  localparam int N  = MUL_BITS_PER_CYCLE;
  localparam int K  = 32 / N;
  localparam int CW = $clog2(K + 1);

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
                         OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
                         OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
                         OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mplier, prod;
  logic [CW-1:0] cnt;

  logic [31:0] mul_rd_data;
  logic        mul_rd_we, mul_rd_data_sel, mul_ld_byte_or_word;
  logic [3:0]  mul_des_reg_num, mul_mem_write_en;

  logic [31:0] alu_result;
  logic        alu_writes;
  logic [31:0] prod_step, mplier_shifted;
  logic        last_cycle, mul_accept, alu_fire, mul_done;

  // Single-cycle ALU. Carry-using opcodes have no carry-in here and
  // behave as their plain counterparts; compare/test ops never write back.
  always_comb begin
    alu_result = 32'd0;
    alu_writes = 1'b1;
    unique case (IDEX_alu_op)
      OP_AND, OP_TST:         alu_result = IDEX_op_a & IDEX_op_b;
      OP_EOR, OP_TEQ:         alu_result = IDEX_op_a ^ IDEX_op_b;
      OP_SUB, OP_SBC, OP_CMP: alu_result = IDEX_op_a - IDEX_op_b;
      OP_RSB, OP_RSC:         alu_result = IDEX_op_b - IDEX_op_a;
      OP_ADD, OP_ADC, OP_CMN: alu_result = IDEX_op_a + IDEX_op_b;
      OP_ORR:                 alu_result = IDEX_op_a | IDEX_op_b;
      OP_MOV:                 alu_result = IDEX_op_b;
      OP_BIC:                 alu_result = IDEX_op_a & ~IDEX_op_b;
      OP_MVN:                 alu_result = ~IDEX_op_b;
      default:                alu_result = 32'd0;
    endcase
    if (IDEX_alu_op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN})
      alu_writes = 1'b0;
  end

  // One radix-2^N step of the multiply; only the low 32 bits matter.
  assign prod_step      = prod + mcand * {{(32-N){1'b0}}, mplier[N-1:0]};
  assign mplier_shifted = mplier >> N;

`ifdef ARM_EX_MUL_EARLY_TERM_EN
  assign last_cycle = (cnt == CW'(1)) || (mplier_shifted == 32'd0);
`else
  assign last_cycle = (cnt == CW'(1));
`endif

  assign mul_accept = (state == IDLE) && IDEX_valid && IDEX_is_mul && !flush;
  assign alu_fire   = (state == IDLE) && IDEX_valid && !IDEX_is_mul && !flush;
  assign mul_done   = (state == BUSY) && last_cycle && !flush;

  // The final BUSY cycle releases the stall so upstream advances on the
  // same edge that writes the product into EX/MEM.
  assign ex_stall = rst_b && !flush &&
                    (mul_accept || ((state == BUSY) && !last_cycle));

  // Multiplier FSM next state; flush always wins over progress.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (mul_accept) state_nxt = BUSY;
        BUSY: if (last_cycle) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Multiplier datapath and latched controls of the instruction in flight.
  always_ff @(posedge clk) begin
    if (mul_accept) begin
      mcand               <= IDEX_op_a;
      mplier              <= IDEX_op_b;
      prod                <= IDEX_mul_acc ? IDEX_acc : 32'd0;
      cnt                 <= CW'(K);
      mul_rd_data         <= IDEX_rd_data;
      mul_rd_we           <= IDEX_rd_we;
      mul_rd_data_sel     <= IDEX_rd_data_sel;
      mul_des_reg_num     <= IDEX_des_reg_num;
      mul_mem_write_en    <= IDEX_mem_write_en;
      mul_ld_byte_or_word <= IDEX_ld_byte_or_word;
    end else if (state == BUSY) begin
      prod   <= prod_step;
      mcand  <= mcand << N;
      mplier <= mplier_shifted;
      cnt    <= cnt - CW'(1);
    end
  end

  // EX/MEM register: ALU result, completed product, or a bubble. Bubbles only
  // clear the fields that could cause side effects downstream.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      EXMEM_valid           <= 1'b0;
      EXMEM_data_result     <= 32'd0;
      EXMEM_rd_data         <= 32'd0;
      EXMEM_rd_we           <= 1'b0;
      EXMEM_rd_data_sel     <= 1'b0;
      EXMEM_des_reg_num     <= 4'd0;
      EXMEM_mem_write_en    <= 4'd0;
      EXMEM_ld_byte_or_word <= 1'b0;
    end else if (alu_fire) begin
      EXMEM_valid           <= 1'b1;
      EXMEM_data_result     <= alu_result;
      EXMEM_rd_data         <= IDEX_rd_data;
      EXMEM_rd_we           <= IDEX_rd_we && alu_writes;
      EXMEM_rd_data_sel     <= IDEX_rd_data_sel;
      EXMEM_des_reg_num     <= IDEX_des_reg_num;
      EXMEM_mem_write_en    <= IDEX_mem_write_en;
      EXMEM_ld_byte_or_word <= IDEX_ld_byte_or_word;
    end else if (mul_done) begin
      EXMEM_valid           <= 1'b1;
      EXMEM_data_result     <= prod_step;
      EXMEM_rd_data         <= mul_rd_data;
      EXMEM_rd_we           <= mul_rd_we;
      EXMEM_rd_data_sel     <= mul_rd_data_sel;
      EXMEM_des_reg_num     <= mul_des_reg_num;
      EXMEM_mem_write_en    <= mul_mem_write_en;
      EXMEM_ld_byte_or_word <= mul_ld_byte_or_word;
    end else begin
      EXMEM_valid        <= 1'b0;
      EXMEM_rd_we        <= 1'b0;
      EXMEM_mem_write_en <= 4'd0;
    end
  end

endmodule
